// File: rtl/traffic_pkg.sv
// Shared types and helpers for the N-phase traffic light controller.
// Lamp colour codes, FSM state encoding and duration saturation.
package traffic_pkg;

  localparam logic [1:0] LT_GREEN  = 2'b00;
  localparam logic [1:0] LT_YELLOW = 2'b01;
  localparam logic [1:0] LT_RED    = 2'b10;
  localparam logic [1:0] LT_OFF    = 2'b11;

  typedef enum logic [1:0] {
    S_GREEN,
    S_YELLOW,
    S_ALLRED,
    S_FLASH
  } state_e;

  // Timer reload for a programmed duration: a zero duration still lasts one tick.
  function automatic logic [15:0] sat_dur(input logic [15:0] cfg);
    return (cfg == 16'd0) ? 16'd0 : cfg - 16'd1;
  endfunction

endpackage

// File: rtl/traffic_light_ctrl_n_timer.sv
// Loadable tick-enabled down-counter for state durations, plus the
// saturating count of ticks spent in the current green.
module tl_phase_timer #(
  parameter int TW      = 6,
  parameter int RST_VAL = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          el_clr,
  input  logic          el_inc,
  output logic          done,
  output logic [TW-1:0] elapsed
);

  logic [TW-1:0] count_q, count_d;
  logic [TW-1:0] el_q, el_d;

  always_comb begin
    count_d = count_q;
    if (load)
      count_d = load_val;
    else if (tick && (count_q != '0))
      count_d = count_q - TW'(1);
  end

  always_comb begin
    el_d = el_q;
    if (el_clr)
      el_d = '0;
    else if (tick && el_inc && (el_q != '1))
      el_d = el_q + TW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= TW'(RST_VAL);
      el_q    <= '0;
    end else begin
      count_q <= count_d;
      el_q    <= el_d;
    end
  end

  assign done    = (count_q == '0);
  assign elapsed = el_q;

endmodule

// File: rtl/traffic_light_ctrl_n.sv
// N-phase round-robin intersection controller with all-red clearance,
// call latching with minimum-green early exit, and flashing night mode.
module traffic_light_ctrl_n
  import traffic_pkg::*;
#(
  parameter int NUM_PHASES = 2,
  parameter int TW         = 6,
  parameter int GREEN_DEF  = 10,
  parameter int MIN_GREEN  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick,
  input  logic [TW-1:0]                 green_time,
  input  logic [TW-1:0]                 yellow_time,
  input  logic [TW-1:0]                 allred_time,
  input  logic [NUM_PHASES-1:0]         ped_req,
  input  logic                          flash_mode,
  output logic [2*NUM_PHASES-1:0]       lights,
  output logic [$clog2(NUM_PHASES)-1:0] phase,
  output logic [NUM_PHASES-1:0]         pending
);

  localparam int PW = $clog2(NUM_PHASES);

  state_e                state_q, state_d;
  logic [PW-1:0]         phase_q, phase_d;
  logic [NUM_PHASES-1:0] pend_q, pend_d;
  logic                  blink_q, blink_d;
  logic                  ret_q, ret_d;

  logic                  load, el_clr, el_inc, done;
  logic [TW-1:0]         load_val, elapsed;
  logic [NUM_PHASES-1:0] cur_mask, nxt_mask;
  logic [PW-1:0]         phase_inc;
  logic                  other_pend;

  tl_phase_timer #(
    .TW      (TW),
    .RST_VAL (GREEN_DEF - 1)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .load     (load),
    .load_val (load_val),
    .el_clr   (el_clr),
    .el_inc   (el_inc),
    .done     (done),
    .elapsed  (elapsed)
  );

  assign cur_mask   = NUM_PHASES'(1) << phase_q;
  assign other_pend = |(pend_q & ~cur_mask);
  assign phase_inc  = (phase_q == PW'(NUM_PHASES - 1)) ? '0 : phase_q + PW'(1);

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    blink_d  = blink_q;
    ret_d    = ret_q;
    pend_d   = pend_q | ped_req;
    nxt_mask = '0;
    load     = 1'b0;
    load_val = '0;
    el_clr   = 1'b0;
    el_inc   = 1'b0;
    if (tick) begin
      unique case (state_q)
        S_GREEN: begin
          if (done || flash_mode ||
              (other_pend && (elapsed >= TW'(MIN_GREEN - 1)))) begin
            state_d  = S_YELLOW;
            load     = 1'b1;
            load_val = TW'(sat_dur(16'(yellow_time)));
          end else begin
            el_inc = 1'b1;
          end
        end
        S_YELLOW: begin
          if (done) begin
            state_d  = S_ALLRED;
            load     = 1'b1;
            load_val = TW'(sat_dur(16'(allred_time)));
          end
        end
        S_ALLRED: begin
          if (done) begin
            if (flash_mode) begin
              state_d = S_FLASH;
            end else begin
              // Leaving night mode restarts the cycle on phase 0.
              state_d  = S_GREEN;
              phase_d  = ret_q ? '0 : phase_inc;
              ret_d    = 1'b0;
              load     = 1'b1;
              load_val = TW'(sat_dur(16'(green_time)));
              el_clr   = 1'b1;
              nxt_mask = NUM_PHASES'(1) << phase_d;
              pend_d   = (pend_q | ped_req) & ~nxt_mask;
            end
          end
        end
        S_FLASH: begin
          if (!flash_mode) begin
            state_d  = S_ALLRED;
            load     = 1'b1;
            load_val = TW'(sat_dur(16'(allred_time)));
            blink_d  = 1'b0;
            ret_d    = 1'b1;
          end else begin
            blink_d = ~blink_q;
          end
        end
        default: state_d = S_GREEN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_GREEN;
      phase_q <= '0;
      pend_q  <= '0;
      blink_q <= 1'b0;
      ret_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      pend_q  <= pend_d;
      blink_q <= blink_d;
      ret_q   <= ret_d;
    end
  end

  // Lamp decode from registered state only.
  always_comb begin
    lights = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      unique case (state_q)
        S_GREEN:  lights[2*i +: 2] = (phase_q == PW'(i)) ? LT_GREEN  : LT_RED;
        S_YELLOW: lights[2*i +: 2] = (phase_q == PW'(i)) ? LT_YELLOW : LT_RED;
        S_ALLRED: lights[2*i +: 2] = LT_RED;
        S_FLASH: begin
          if (i == 0) lights[2*i +: 2] = blink_q ? LT_YELLOW : LT_OFF;
          else        lights[2*i +: 2] = blink_q ? LT_RED    : LT_OFF;
        end
        default:  lights[2*i +: 2] = LT_RED;
      endcase
    end
  end

  assign phase   = phase_q;
  assign pending = pend_q;

endmodule

// File: tb/tb_traffic_light_ctrl_n.sv
// Scoreboard bench for traffic_light_ctrl_n (3 phases): a tick-level
// reference model queues expected outputs each cycle; directed checks on top.
module tb_traffic_light_ctrl_n;

  localparam int NP   = 3;
  localparam int TW   = 6;
  localparam int GDEF = 10;
  localparam int MING = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            tick = 1'b0;
  logic [TW-1:0]   green_time = 6'd10;
  logic [TW-1:0]   yellow_time = 6'd3;
  logic [TW-1:0]   allred_time = 6'd1;
  logic [NP-1:0]   ped_req = '0;
  logic            flash_mode = 1'b0;
  logic [2*NP-1:0] lights;
  logic [1:0]      phase;
  logic [NP-1:0]   pending;

  traffic_light_ctrl_n #(
    .NUM_PHASES (NP),
    .TW         (TW),
    .GREEN_DEF  (GDEF),
    .MIN_GREEN  (MING)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .green_time  (green_time),
    .yellow_time (yellow_time),
    .allred_time (allred_time),
    .ped_req     (ped_req),
    .flash_mode  (flash_mode),
    .lights      (lights),
    .phase       (phase),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [10:0] sb_q[$];

  // Reference model: m_left = ticks remaining in the current state.
  int m_st, m_left, m_el, m_ph;
  bit m_blink, m_ret;
  logic [NP-1:0] m_pend;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  task automatic model_reset();
    m_st = 0; m_left = GDEF; m_el = 0; m_ph = 0;
    m_blink = 0; m_ret = 0; m_pend = '0;
  endtask

  task automatic model_step();
    logic [NP-1:0] p;
    logic [NP-1:0] others;
    p = m_pend | ped_req;
    others = m_pend;
    others[m_ph] = 1'b0;
    if (tick) begin
      case (m_st)
        0: begin
          if (m_left == 1 || flash_mode || (others != '0 && m_el + 1 >= MING)) begin
            m_st = 1; m_left = max1(int'(yellow_time));
          end else begin
            m_left--; m_el++;
          end
        end
        1: begin
          if (m_left == 1) begin m_st = 2; m_left = max1(int'(allred_time)); end
          else m_left--;
        end
        2: begin
          if (m_left == 1) begin
            if (flash_mode) m_st = 3;
            else begin
              m_ph = m_ret ? 0 : (m_ph + 1) % NP;
              m_ret = 0; m_st = 0; m_el = 0;
              m_left = max1(int'(green_time));
              p[m_ph] = 1'b0;
            end
          end else m_left--;
        end
        default: begin
          if (!flash_mode) begin
            m_st = 2; m_left = max1(int'(allred_time)); m_blink = 0; m_ret = 1;
          end else m_blink = ~m_blink;
        end
      endcase
    end
    m_pend = p;
  endtask

  function automatic logic [10:0] exp_vec();
    logic [2*NP-1:0] l;
    logic [1:0] c;
    for (int i = 0; i < NP; i++) begin
      case (m_st)
        0: c = (i == m_ph) ? 2'b00 : 2'b10;
        1: c = (i == m_ph) ? 2'b01 : 2'b10;
        2: c = 2'b10;
        default: c = (i == 0) ? (m_blink ? 2'b01 : 2'b11) : (m_blink ? 2'b10 : 2'b11);
      endcase
      l[2*i +: 2] = c;
    end
    return {l, 2'(m_ph), m_pend};
  endfunction

  task automatic step(input bit t);
    @(negedge clk);
    tick = t;
    model_step();
    sb_q.push_back(exp_vec());
    @(posedge clk);
    #1;
    tick = 1'b0;
    if (sb_q.size() == 0) check_eq("sb_empty", 32'd0, 32'd1);
    else check_eq("sb", {lights, phase, pending}, sb_q.pop_front());
  endtask

  task automatic run_ticks(input int n);
    repeat (n) begin
      step(0); step(0); step(0); step(1);
    end
  endtask

  task automatic wait_green(input int p);
    bit found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      run_ticks(1);
      if (phase == 2'(p) && lights[2*p +: 2] == 2'b00) found = 1;
    end
    check_eq("wait_green", 32'(found), 32'd1);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_lights", 32'(lights), 32'h28);
    check_eq("rst_phase", 32'(phase), 32'd0);
    check_eq("rst_pending", 32'(pending), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Nominal round robin, no calls
    run_ticks(9);  check_eq("g_tick9", 32'(lights), 32'h28);
    run_ticks(1);  check_eq("y_tick10", 32'(lights), 32'h29);
    run_ticks(3);  check_eq("ar_tick13", 32'(lights), 32'h2a);
    run_ticks(1);  check_eq("p1_tick14", 32'(lights), 32'h22);
    check_eq("p1_phase", 32'(phase), 32'd1);
    run_ticks(28); check_eq("p0_tick42", 32'(lights), 32'h28);
    check_eq("p0_phase", 32'(phase), 32'd0);

    // Call for phase 2 at elapsed=1 cuts green at MIN_GREEN
    run_ticks(1);
    ped_req = 3'b100; step(0); ped_req = '0;
    run_ticks(2);  check_eq("early_still_g", 32'(lights[1:0]), 32'd0);
    check_eq("early_pend", 32'(pending), 32'h4);
    run_ticks(1);  check_eq("early_y", 32'(lights[1:0]), 32'd1);
    run_ticks(4);  check_eq("rr_p1", 32'(phase), 32'd1);
    check_eq("rr_p1_pend", 32'(pending), 32'h4);
    run_ticks(8);  check_eq("p2_green", 32'(lights), 32'h0a);
    check_eq("p2_pend_clr", 32'(pending), 32'd0);

    // Zero durations last one tick each
    green_time = '0; yellow_time = '0;
    run_ticks(12); check_eq("z_p0_g", 32'(lights), 32'h28);
    run_ticks(1);  check_eq("z_p0_y", 32'(lights), 32'h29);
    run_ticks(1);  check_eq("z_ar", 32'(lights), 32'h2a);
    run_ticks(1);  check_eq("z_p1_g", 32'(lights), 32'h22);
    green_time = 6'd10; yellow_time = 6'd3;

    // Flash entry and exit
    wait_green(0);
    run_ticks(2);
    flash_mode = 1'b1;
    run_ticks(1);  check_eq("fl_y", 32'(lights), 32'h29);
    run_ticks(3);  check_eq("fl_ar", 32'(lights), 32'h2a);
    run_ticks(1);  check_eq("fl_off", 32'(lights), 32'h3f);
    run_ticks(1);  check_eq("fl_on", 32'(lights), 32'h29);
    run_ticks(1);  check_eq("fl_off2", 32'(lights), 32'h3f);
    flash_mode = 1'b0;
    run_ticks(1);  check_eq("fx_ar", 32'(lights), 32'h2a);
    run_ticks(1);  check_eq("fx_p0", 32'(lights), 32'h28);
    check_eq("fx_phase", 32'(phase), 32'd0);

    // Async reset mid-yellow
    ped_req = 3'b010; step(0); ped_req = '0;
    run_ticks(4);  check_eq("ay_y", 32'(lights), 32'h29);
    check_eq("ay_pend", 32'(pending), 32'h2);
    run_ticks(1);
    #1 rst = 1'b1;
    #1;
    check_eq("arst_lights", 32'(lights), 32'h28);
    check_eq("arst_pending", 32'(pending), 32'd0);
    check_eq("arst_phase", 32'(phase), 32'd0);
    model_reset();
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;

    // Randomised traffic against the model
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 19) == 0) ped_req = NP'($urandom_range(1, 7));
      else ped_req = '0;
      if ($urandom_range(0, 199) == 0) flash_mode = ~flash_mode;
      if ($urandom_range(0, 99) == 0) begin
        green_time  = 6'($urandom_range(0, 6));
        yellow_time = 6'($urandom_range(0, 3));
        allred_time = 6'($urandom_range(0, 2));
      end
      step($urandom_range(0, 2) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_light_ctrl_n.md
Name: traffic_light_ctrl_n

Overview:
- Parametrised N-phase traffic intersection controller. Successor to the fixed 2-direction controller.
- Adds runtime-programmable durations, an all-red clearance interval, pedestrian/vehicle call latching with minimum-green early termination, and a flashing night mode.
- Sits between the 1 Hz tick generator and the lamp driver block; one instance per intersection.

Parameters:
- NUM_PHASES, 2, number of conflicting phases served in round-robin order (2..8).
- TW, 6, width of duration inputs and internal timers.
- GREEN_DEF, 10, green duration in ticks used from reset until the first reload.
- MIN_GREEN, 4, minimum green ticks before a pending call may terminate green early (1..2^TW-1).

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- tick  in  1  one-cycle timing enable (1 Hz); all timing advances only on clk edges with tick=1
- green_time  in  TW  green duration, ticks
- yellow_time  in  TW  yellow duration, ticks
- allred_time  in  TW  all-red clearance duration, ticks
- ped_req  in  NUM_PHASES  per-phase call, level sampled every clk
- flash_mode  in  1  request for night flashing operation
- lights  out  2*NUM_PHASES  per-phase colour; phase i occupies bits [2i+1:2i]; 00 green, 01 yellow, 10 red, 11 off
- phase  out  $clog2(NUM_PHASES)  index of the phase currently served
- pending  out  NUM_PHASES  latched calls

Behaviour:
- Reset and clock: reset rst, asynchronous, active-high; clock clk.
- Reset values: state=GREEN, phase=0, timer=GREEN_DEF-1, elapsed=0, pending=0, blink=0. lights = phase 0 green, all other phases red.
- Outputs are a combinational decode of registered state only. Inputs never reach outputs combinationally.
- States: GREEN, YELLOW, ALLRED, FLASH.
- Duration rule:
  - On every state entry, timer loads max(cfg,1)-1, where cfg is the matching *_time input sampled in the transition cycle.
  - A zero duration behaves as 1 tick.
  - Each state lasts exactly max(cfg,1) ticks unless terminated early.
- Tick rules, non-FLASH states: on each tick, if timer==0 the state transitions; otherwise timer decrements.
- GREEN early termination:
  - elapsed counts ticks spent in the current green, saturating at 2^TW-1.
  - On a tick, GREEN also exits if any pending bit for a phase other than the current one is set and elapsed >= MIN_GREEN-1.
- Transitions:
  - GREEN -> YELLOW.
  - YELLOW -> ALLRED.
  - ALLRED -> FLASH if flash_mode=1; otherwise GREEN with phase=(phase+1) mod NUM_PHASES.
- Flash entry: flash_mode=1 while in GREEN forces exit to YELLOW on the next tick, ignoring MIN_GREEN. Yellow and all-red still run their full durations.
- FLASH:
  - blink toggles on every tick.
  - Phase 0 shows yellow when blink=1, off when blink=0. All other phases show red when blink=1, off when blink=0.
  - On a tick with flash_mode=0: go to ALLRED, reload allred_time, clear blink. After ALLRED, enter GREEN on phase 0.
- Lamp decode per phase i:
  - GREEN/YELLOW: the served phase shows green/yellow; all others show red.
  - ALLRED: every phase shows red.
- Pending calls:
  - pending[i] sets in any cycle where ped_req[i]=1.
  - pending[i] clears in the cycle phase i enters GREEN. Clear wins over a simultaneous set.
  - pending is held, never cleared, while in FLASH.
- Safety invariant: at most one phase is non-red outside FLASH in every cycle.
- No tick: state, timer and outputs hold indefinitely; only pending may change.
- Reset mid-operation returns immediately to the reset values, including from FLASH.

Decomposition:
- traffic_pkg holds:
  - colour constants: GREEN=2'b00, YELLOW=2'b01, RED=2'b10, OFF=2'b11;
  - state enum: GREEN, YELLOW, ALLRED, FLASH;
  - function sat_dur(cfg), returning max(cfg,1)-1.
- One sub-module, tl_phase_timer: TW-bit loadable down-counter with tick enable.
  - Inputs: load, load_val, tick.
  - Outputs: done, asserted when count==0.
  - Also provides the saturating elapsed counter.

Test Plan:
- Reset, then green=10, yellow=3, allred=1, no calls, tick every 4 clk -> phase0 green for 10 ticks, yellow 3, all-red 1, then phase1 green. The cycle returns to phase0 after 28 ticks.
- NUM_PHASES=3, ped_req[2] pulsed during phase0 green at elapsed=1, MIN_GREEN=4 -> green ends after 4 ticks. Phase1 then serves (round-robin order is preserved), and pending[2] clears on phase2 green entry.
- green_time=0, yellow_time=0 -> each of green and yellow lasts exactly 1 tick, and no underflow occurs.
- flash_mode=1 at green tick 2 -> yellow starts on the next tick, then 3 yellow ticks and 1 all-red tick, then FLASH. Phase0 alternates 01/11 and phase1 alternates 10/11 on each tick.
- flash_mode=0 during FLASH -> all-red for allred_time ticks, then phase0 green, and blink is cleared.
- rst asserted asynchronously mid-yellow with no clk edge -> lights immediately read phase0=00 and others=10, and pending=0.
